// File: rtl/eth_fcs_tx.sv
// eth_fcs_tx: transmit-side Ethernet FCS inserter.
//
// Passes a frame byte stream through unchanged. Short frames are zero-padded
// up to MIN_LEN when PAD_EN is set. The 4-byte IEEE 802.3 FCS is then appended,
// low byte first. Both sides use a valid/ready handshake, and there is a single
// registered output stage, so data appears on m_data one cycle after it is
// accepted.
//
// Ports:
//   clk, reset_n         clock; asynchronous active-low reset
//   s_data/s_valid/s_last/s_ready   input byte stream (s_last = last payload byte)
//   m_data/m_valid/m_last/m_ready   output byte stream (m_last = last FCS byte)
//   busy                 high from first accepted byte until the last FCS byte transfers
module eth_fcs_tx #(
    parameter int unsigned MIN_LEN = 60,
    parameter bit          PAD_EN  = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic [7:0] m_data,
    output logic       m_valid,
    output logic       m_last,
    input  logic       m_ready,
    output logic       busy
);

    localparam logic [31:0] CRC_INIT  = 32'hFFFF_FFFF;
    localparam logic [31:0] POLY_REFL = 32'hEDB8_8320;
    localparam logic [15:0] MIN_LEN16 = 16'(MIN_LEN);

    typedef enum logic [1:0] {IDLE, DATA, PAD, FCS} state_t;

    state_t      state_q, state_d;
    logic [31:0] crc_q,   crc_d;
    logic [15:0] len_q,   len_d;
    logic [1:0]  idx_q,   idx_d;
    logic [7:0]  data_q,  data_d;
    logic        valid_q, valid_d;
    logic        last_q,  last_d;
    logic        busy_q,  busy_d;

    logic        out_free, in_phase, in_fire, out_fire;
    logic [15:0] len_inc;
    logic [31:0] fcs;

    // Reflected CRC-32, one byte per call (LSB of the byte first).
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ POLY_REFL) : (r >> 1);
        end
        return r;
    endfunction

    assign out_free = !valid_q || m_ready;
    assign in_phase = (state_q == IDLE) || (state_q == DATA);
    // Held low while in reset so the source never sees a phantom accept.
    assign s_ready  = reset_n && in_phase && out_free;
    assign in_fire  = s_valid && s_ready;
    assign out_fire = valid_q && m_ready;
    // Length only feeds the pad decision, so saturating is enough.
    assign len_inc  = (len_q == 16'hFFFF) ? len_q : len_q + 16'd1;
    assign fcs      = ~crc_q;

    always_comb begin
        state_d = state_q;
        crc_d   = crc_q;
        len_d   = len_q;
        idx_d   = idx_q;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        busy_d  = busy_q;

        // Drain the output register. A new load below overrides this.
        if (out_fire) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            if (last_q) busy_d = 1'b0;
        end

        case (state_q)
            IDLE, DATA: begin
                // In IDLE, crc/len were already reset when the previous FCS
                // finished. A back-to-back frame therefore starts clean.
                if (in_fire) begin
                    data_d  = s_data;
                    valid_d = 1'b1;
                    last_d  = 1'b0;
                    crc_d   = crc_byte(crc_q, s_data);
                    len_d   = len_inc;
                    busy_d  = 1'b1;
                    if (s_last) begin
                        if (PAD_EN && (len_inc < MIN_LEN16)) begin
                            state_d = PAD;
                        end else begin
                            state_d = FCS;
                            idx_d   = 2'd0;
                        end
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            PAD: begin
                if (out_free) begin
                    data_d  = 8'h00;
                    valid_d = 1'b1;
                    last_d  = 1'b0;
                    crc_d   = crc_byte(crc_q, 8'h00);
                    len_d   = len_inc;
                    if (len_inc >= MIN_LEN16) begin
                        state_d = FCS;
                        idx_d   = 2'd0;
                    end
                end
            end
            FCS: begin
                if (out_free) begin
                    data_d  = fcs[{idx_q, 3'b000} +: 8];
                    valid_d = 1'b1;
                    last_d  = (idx_q == 2'd3);
                    idx_d   = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d = IDLE;
                        crc_d   = CRC_INIT;
                        len_d   = 16'd0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            crc_q   <= CRC_INIT;
            len_q   <= 16'd0;
            idx_q   <= 2'd0;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
        end
    end

    assign m_data  = data_q;
    assign m_valid = valid_q;
    assign m_last  = last_q;
    assign busy    = busy_q;

endmodule
